// File: rtl/extog_pkg.sv
// Shared constants, entry layout and the excess-3 to Gray conversion for the extog stream.
package extog_pkg;

   localparam logic [3:0] EX3_MIN  = 4'd3;
   localparam logic [3:0] EX3_MAX  = 4'd12;
   localparam logic [3:0] ERR_GRAY = 4'b0000;

   localparam int unsigned ENTRY_W = 5;

   typedef struct packed {
      logic       err;
      logic [3:0] g;
   } entry_t;

   // Out-of-range codes map to a fixed Gray value with the error flag set.
   function automatic entry_t ex3_to_gray(input logic [3:0] ex);
      entry_t     e;
      logic [3:0] b;
      if (ex >= EX3_MIN && ex <= EX3_MAX) begin
         b     = ex - EX3_MIN;
         e.err = 1'b0;
         e.g   = b ^ (b >> 1);
      end else begin
         e.err = 1'b1;
         e.g   = ERR_GRAY;
      end
      return e;
   endfunction

endpackage

// File: rtl/extog_stream_if.sv
// Handshake and status bundle between a code source, the converter and a Gray consumer.
interface extog_stream_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_ex;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_g;
   logic             out_err;
   logic [CNT_W-1:0] err_count;
   logic [LVL_W-1:0] level;

   modport master (
      output in_valid, in_ex, out_ready,
      input  in_ready, out_valid, out_g, out_err, err_count, level
   );

   modport slave (
      input  in_valid, in_ex, out_ready,
      output in_ready, out_valid, out_g, out_err, err_count, level
   );

endinterface

// File: rtl/extog_fifo.sv
// Synchronous FIFO with occupancy output; storage is cleared on reset so the head reads zero.
module extog_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_comb begin
      level_d = level_q;
      unique case ({do_push, do_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/extog_stream.sv
// Streaming excess-3 to Gray converter: converts on accept, buffers in a FIFO, counts bad codes.
module extog_stream
   import extog_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic           clk,
   input logic           rst,
   extog_stream_if.slave bus
);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   entry_t             conv;
   entry_t             head;
   logic [ENTRY_W-1:0] rdata;
   logic [LVL_W-1:0]   level;
   logic               push, pop, full, empty;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

   always_comb conv = ex3_to_gray(bus.in_ex);

   // No pass-through when full: in_ready depends only on stored occupancy.
   assign push = bus.in_valid & ~full;
   assign pop  = ~empty & bus.out_ready;
   assign head = entry_t'(rdata);

   extog_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (conv),
      .rdata_o (rdata),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (push && conv.err && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.in_ready  = ~full;
   assign bus.out_valid = ~empty;
   assign bus.out_g     = head.g;
   assign bus.out_err   = head.err;
   assign bus.err_count = err_cnt_q;
   assign bus.level     = level;

endmodule
